// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the multi-cycle stage sequencer:
// sequencer state encoding, default stage map and width helper.
package stage_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

    localparam int DEF_N_STAGES  = 5;
    localparam int DEF_RAM_STAGE = 3;
    localparam int DEF_REG_STAGE = 4;
    localparam int DEF_CNT_W     = 32;

    function automatic int stage_w(input int n);
        return ($clog2(n) > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stage_sequencer.sv
// Multi-cycle stage sequencer: walks one instruction through
// N_STAGES pipeline-register enables, with busy, flush and halt.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter int N_STAGES  = DEF_N_STAGES,
    parameter int RAM_STAGE = DEF_RAM_STAGE,
    parameter int REG_STAGE = DEF_REG_STAGE,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_STAGES-1:0]           stage_busy,
    input  logic                          flush,
    input  logic                          halt_req,
    input  logic                          resume,
    output logic [N_STAGES-1:0]           stage_wren,
    output logic                          pc_wren,
    output logic                          ram_wren,
    output logic                          reg_wren,
    output logic                          stage_reset_n,
    output logic [stage_w(N_STAGES)-1:0]  cur_stage,
    output logic                          retire,
    output logic                          halted,
    output logic [CNT_W-1:0]              retire_cnt
);

    localparam int SW = stage_w(N_STAGES);

    seq_state_e     state_q, state_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic stage_valid;
    logic busy_cur;
    logic is_last;
    logic run;
    logic complete;

    // Stage index is resolved by loop so non power-of-two depths
    // never index past the busy/enable vectors.
    always_comb begin
        stage_valid = 1'b0;
        busy_cur    = 1'b0;
        for (int k = 0; k < N_STAGES; k++) begin
            if (stage_q == SW'(k)) begin
                stage_valid = 1'b1;
                busy_cur    = stage_busy[k];
            end
        end
    end

    assign is_last  = (stage_q == SW'(N_STAGES - 1));
    assign run      = (state_q == ST_RUN) && stage_valid;
    assign complete = run && !flush && !busy_cur;

    always_comb begin
        stage_wren = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            stage_wren[k] = complete && (stage_q == SW'(k));
        end
    end

    assign pc_wren       = stage_wren[0];
    assign ram_wren      = stage_wren[RAM_STAGE];
    assign reg_wren      = stage_wren[REG_STAGE];
    assign retire        = stage_wren[N_STAGES-1];
    assign stage_reset_n = (state_q != ST_INIT);
    assign halted        = (state_q == ST_HALTED);
    assign cur_stage     = run ? stage_q : '0;
    assign retire_cnt    = cnt_q;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        unique case (state_q)
            ST_INIT: begin
                state_d = ST_RUN;
                stage_d = '0;
            end
            ST_RUN: begin
                if (!stage_valid) begin
                    state_d = ST_INIT;
                    stage_d = '0;
                end else if (flush) begin
                    stage_d = '0;
                end else if (busy_cur) begin
                    stage_d = stage_q;
                end else if (is_last) begin
                    stage_d = '0;
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end
                end else begin
                    stage_d = stage_q + SW'(1);
                end
            end
            ST_HALTED: begin
                stage_d = '0;
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
                stage_d = '0;
            end
        endcase
    end

    assign cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_INIT;
            stage_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
